// File: rtl/ram_responder.sv
`default_nettype none
// ============================================================================
// Module   : ram_responder
// Purpose  : Memory-side responder for the cache RAM port. Holds a
//            2**a_width word array and answers each single-cycle request
//            after a fixed latency of `lat` cycles. Read data is returned on
//            the shared tri-state bus during the one-cycle response window.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   d_width  data bus width
//   a_width  address width (array depth is 2**a_width)
//   lat      request-to-response latency in cycles, legal range 1..15
// Ports:
//   clk      clock, all state changes on the rising edge
//   clr      synchronous active-high reset; also clears the whole array
//   addr_in  request address
//   data     shared bus: write data in, read data out (high-Z otherwise)
//   rw_in    1 = read, 0 = write
//   ce_in    request strobe
//   rdy      one-cycle pulse marking the response cycle
//   busy     high from the accept cycle through the cycle before rdy
//   err      one-cycle pulse for a request dropped while waiting
// Optional feature:
//   RAM_ERRCHK_EN  when defined, a request arriving in WAIT pulses err;
//                  when undefined, such requests are ignored and err is 0.
// ============================================================================
module ram_responder #(
  parameter int d_width = 8,
  parameter int a_width = 8,
  parameter int lat     = 2
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [a_width-1:0] addr_in,
  inout  wire  [d_width-1:0] data,
  input  logic               rw_in,
  input  logic               ce_in,
  output logic               rdy,
  output logic               busy,
  output logic               err
);

  localparam int         DEPTH  = 2 ** a_width;
  localparam logic [3:0] LAT_M1 = 4'(lat - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [a_width-1:0] addr_q, addr_d;
  logic               rw_q, rw_d;
  logic [d_width-1:0] wdata_q, wdata_d;
  logic [d_width-1:0] rd_q, rd_d;
  logic               rdy_q, rdy_d;
  logic [d_width-1:0] mem_q [DEPTH];

  // The array operation happens on the edge that enters RESP. From WAIT it
  // uses the captured request; otherwise (lat == 1, entering RESP on the
  // accept edge itself) the live inputs are the request.
  logic               enter_resp;
  logic [a_width-1:0] op_addr;
  logic               op_rw;
  logic [d_width-1:0] op_wdata;

`ifdef RAM_ERRCHK_EN
  logic err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
`ifdef RAM_ERRCHK_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      // RESP doubles as an accept cycle for back-to-back requests.
      IDLE, RESP: begin
        state_d = IDLE;
        if (ce_in) begin
          addr_d  = addr_in;
          rw_d    = rw_in;
          wdata_d = data;
          cnt_d   = LAT_M1;
          state_d = (lat == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
        end
`ifdef RAM_ERRCHK_EN
        // Request dropped; outstanding request and array untouched.
        err_d = ce_in;
`endif
      end
      default: state_d = IDLE;
    endcase

    enter_resp = (state_d == RESP);
    if (state_q == WAIT) begin
      op_addr  = addr_q;
      op_rw    = rw_q;
      op_wdata = wdata_q;
    end else begin
      op_addr  = addr_in;
      op_rw    = rw_in;
      op_wdata = data;
    end

    rd_d = rd_q;
    if (enter_resp && op_rw) begin
      rd_d = mem_q[op_addr];
    end
    rdy_d = enter_resp;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      rd_q    <= '0;
      rdy_q   <= 1'b0;
`ifdef RAM_ERRCHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      rdy_q   <= rdy_d;
`ifdef RAM_ERRCHK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Reset clears every word in one cycle and suppresses any pending commit.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (enter_resp && !op_rw) begin
      mem_q[op_addr] <= op_wdata;
    end
  end

  // Bus is owned by the responder only in the response cycle of a read.
  assign data = (state_q == RESP && rw_q) ? rd_q : {d_width{1'bz}};
  assign rdy  = rdy_q;
  // Including the accept cycle makes busy span exactly lat cycles before rdy.
  assign busy = (state_q == WAIT) || ce_in;

`ifdef RAM_ERRCHK_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire
